// File: rtl/line_clear_engine.sv
// line_clear_engine
//   Compacts a 20-row x 10-column falling-block board after a piece locks.
//   A pass reads every row from the bottom (19) to the top (0), copies each
//   non-full row down to the next free destination row and skips full rows.
//   The rows left over at the top are then written with zeros. When the pass
//   ends, the number of cleared rows is latched and added to a saturating score.
//
// Ports
//   i_clk       system clock, all state on the rising edge
//   i_rst_n     asynchronous active-low reset
//   i_start     one-cycle pass request, honoured only while idle
//   i_new_game  clears the accumulated score on the next edge
//   o_rd_row    board read address (0 = top, 19 = bottom)
//   i_rd_data   row contents for o_rd_row, 3 bits per cell, 0 = empty
//   o_wr_en     row write strobe
//   o_wr_row    row write address
//   o_wr_data   row write data
//   o_busy      high for the whole pass, including the completion cycle
//   o_done      one-cycle completion pulse
//   o_lines     rows cleared by the last pass
//   o_score     accumulated score, saturating at 16'hFFFF
module line_clear_engine (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_new_game,
  output logic [4:0]  o_rd_row,
  input  logic [29:0] i_rd_data,
  output logic        o_wr_en,
  output logic [4:0]  o_wr_row,
  output logic [29:0] o_wr_data,
  output logic        o_busy,
  output logic        o_done,
  output logic [4:0]  o_lines,
  output logic [15:0] o_score
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic [4:0]  src_r, src_s;
  logic [4:0]  dst_r, dst_s;
  logic [4:0]  cnt_r, cnt_s;
  logic [4:0]  lines_r;
  logic [15:0] score_r;

  // A row is full when none of its ten cells holds the empty code.
  function automatic logic row_full(input logic [29:0] row);
    logic full;
    full = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (row[3*c +: 3] == 3'd0) begin
        full = 1'b0;
      end else begin
        full = full;
      end
    end
    return full;
  endfunction

  // Score awarded for clearing n rows in one pass; four or more earn the maximum.
  function automatic logic [15:0] score_inc(input logic [4:0] n);
    logic [15:0] inc;
    case (n)
      5'd0:    inc = 16'd0;
      5'd1:    inc = 16'd1;
      5'd2:    inc = 16'd3;
      5'd3:    inc = 16'd5;
      default: inc = 16'd8;
    endcase
    return inc;
  endfunction

  // Saturating 16-bit add: the carry out selects the ceiling value.
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  // Next-state, pointer updates and board-port drive for the compaction pass.
  always_comb begin
    state_s   = state_r;
    src_s     = src_r;
    dst_s     = dst_r;
    cnt_s     = cnt_r;
    o_rd_row  = 5'd0;
    o_wr_en   = 1'b0;
    o_wr_row  = 5'd0;
    o_wr_data = 30'd0;
    case (state_r)
      IDLE: begin
        if (i_start) begin
          state_s = SCAN;
          src_s   = 5'd19;
          dst_s   = 5'd19;
          cnt_s   = 5'd0;
        end else begin
          state_s = IDLE;
        end
      end
      SCAN: begin
        o_rd_row = src_r;
        if (row_full(i_rd_data)) begin
          cnt_s = cnt_r + 5'd1;
        end else begin
          // Rows that stay are always rewritten, even onto themselves.
          o_wr_en   = 1'b1;
          o_wr_row  = dst_r;
          o_wr_data = i_rd_data;
          if (dst_r != 5'd0) begin
            dst_s = dst_r - 5'd1;
          end else begin
            dst_s = dst_r;
          end
        end
        // cnt_s includes row 0's own verdict, so the FILL decision sees all 20 rows.
        if (src_r == 5'd0) begin
          state_s = (cnt_s != 5'd0) ? FILL : DONE;
        end else begin
          src_s = src_r - 5'd1;
        end
      end
      FILL: begin
        // After SCAN, dst points at row cnt-1, so zeroing down to row 0 takes cnt cycles.
        o_wr_en  = 1'b1;
        o_wr_row = dst_r;
        if (dst_r == 5'd0) begin
          state_s = DONE;
        end else begin
          dst_s = dst_r - 5'd1;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Pass control registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= IDLE;
      src_r   <= 5'd19;
      dst_r   <= 5'd19;
      cnt_r   <= 5'd0;
    end else begin
      state_r <= state_s;
      src_r   <= src_s;
      dst_r   <= dst_s;
      cnt_r   <= cnt_s;
    end
  end

  // Cleared-row count, latched at completion and held until the next one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lines_r <= 5'd0;
    end else if (state_r == DONE) begin
      lines_r <= cnt_r;
    end else begin
      lines_r <= lines_r;
    end
  end

  // Score accumulator; a new game wins over a same-cycle completion.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      score_r <= 16'd0;
    end else if (i_new_game) begin
      score_r <= 16'd0;
    end else if (state_r == DONE) begin
      score_r <= sat_add(score_r, score_inc(cnt_r));
    end else begin
      score_r <= score_r;
    end
  end

  assign o_busy  = (state_r != IDLE);
  assign o_done  = (state_r == DONE);
  assign o_lines = lines_r;
  assign o_score = score_r;

endmodule

// File: tb/tb_line_clear_engine.sv
// Scoreboard bench for line_clear_engine. Stimulus loads a board into a model
// memory, computes the expected compacted board, line count, score and done
// cycle from the game rules, and queues them; a monitor checks each o_done.
module tb_line_clear_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        new_game;
  logic [4:0]  rd_row;
  logic [29:0] rd_data;
  logic        wr_en;
  logic [4:0]  wr_row;
  logic [29:0] wr_data;
  logic        busy;
  logic        done;
  logic [4:0]  lines;
  logic [15:0] score;

  line_clear_engine dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_new_game (new_game),
    .o_rd_row   (rd_row),
    .i_rd_data  (rd_data),
    .o_wr_en    (wr_en),
    .o_wr_row   (wr_row),
    .o_wr_data  (wr_data),
    .o_busy     (busy),
    .o_done     (done),
    .o_lines    (lines),
    .o_score    (score)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]   lines;
    logic [15:0]  score;
    int           done_cyc;
    logic [599:0] rows;
  } exp_t;

  exp_t        q[$];
  logic [29:0] board[20];
  logic [29:0] load_board[20];
  logic [29:0] snap[20];
  logic        load_req = 1'b0;
  int          cyc = 0;
  int          writes = 0;
  int          tests = 0;
  int          fails = 0;
  int          model_score = 0;

  assign rd_data = (rd_row < 5'd20) ? board[rd_row] : 30'd0;

  // Board memory, write counter and cycle counter.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (load_req) begin
      for (int i = 0; i < 20; i++) board[i] <= load_board[i];
      writes <= 0;
    end else if (wr_en) begin
      if (wr_row < 5'd20) board[wr_row] <= wr_data;
      writes <= writes + 1;
    end
  end

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Monitor: every write must target a real row; every done is scored.
  always begin
    exp_t e;
    @(negedge clk);
    if (rst_n && wr_en) check("wr_row_in_range", int'(wr_row < 5'd20), 1);
    if (rst_n && done) begin
      if (q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = q.pop_front();
        check("done_latency", cyc, e.done_cyc);
        check("busy_in_done", int'(busy), 1);
        check("writes_per_pass", writes, 20);
        for (int r = 0; r < 20; r++)
          check($sformatf("board_row%0d", r), int'(board[r]), int'(e.rows[r*30 +: 30]));
        @(negedge clk);
        check("done_one_cycle", int'(done), 0);
        check("busy_after_done", int'(busy), 0);
        check("lines", int'(lines), int'(e.lines));
        check("score", int'(score), int'(e.score));
      end
    end
  end

  function automatic logic [29:0] rand_row(input bit full);
    logic [29:0] r;
    int hole;
    for (int c = 0; c < 10; c++)
      r[3*c +: 3] = full ? 3'($urandom_range(1, 7)) : 3'($urandom_range(0, 7));
    if (!full) begin
      hole = $urandom_range(0, 9);
      r[3*hole +: 3] = 3'd0;
    end
    return r;
  endfunction

  function automatic bit is_full(input logic [29:0] r);
    int empties = 0;
    for (int c = 0; c < 10; c++) if (r[3*c +: 3] == 3'd0) empties++;
    return empties == 0;
  endfunction

  function automatic int points(input int n);
    if (n >= 4) return 8;
    if (n == 3) return 5;
    if (n == 2) return 3;
    return n;
  endfunction

  // Fill load_board: rows listed in full_mask are full, others have a hole.
  task automatic make_board(input logic [19:0] full_mask);
    for (int r = 0; r < 20; r++) load_board[r] = rand_row(full_mask[r]);
  endtask

  task automatic run_pass(input bit ng_in_done, input bit pulse_mid);
    exp_t e;
    int kept = 0;
    int cnt;
    int t = 0;
    e.rows = '0;
    // Surviving rows settle at the bottom in their original order.
    for (int r = 19; r >= 0; r--) begin
      if (!is_full(load_board[r])) begin
        e.rows[(19 - kept)*30 +: 30] = load_board[r];
        kept++;
      end
    end
    cnt = 20 - kept;
    if (ng_in_done) model_score = 0;
    else if (model_score + points(cnt) > 65535) model_score = 65535;
    else model_score = model_score + points(cnt);
    e.lines = 5'(cnt);
    e.score = 16'(model_score);
    @(negedge clk); load_req = 1'b1;
    @(negedge clk); load_req = 1'b0;
    start = 1'b1;
    e.done_cyc = cyc + 21 + cnt;
    q.push_back(e);
    @(negedge clk); start = 1'b0;
    if (pulse_mid) begin
      repeat (5) @(negedge clk);
      start = 1'b1;
      @(negedge clk); start = 1'b0;
    end
    while (!done && t < 80) begin
      @(negedge clk);
      t++;
    end
    check("done_timeout", int'(t < 80), 1);
    if (ng_in_done) begin
      new_game = 1'b1;
      @(negedge clk); new_game = 1'b0;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic reset_mid_pass();
    int diffs = 0;
    make_board(20'h80421);
    @(negedge clk); load_req = 1'b1;
    @(negedge clk); load_req = 1'b0;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    check("busy_before_reset", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_rd_row", int'(rd_row), 0);
    check("rst_score", int'(score), 0);
    check("rst_lines", int'(lines), 0);
    for (int r = 0; r < 20; r++) snap[r] = board[r];
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    for (int r = 0; r < 20; r++) if (board[r] != snap[r]) diffs++;
    check("no_write_after_reset", diffs, 0);
    check("idle_after_reset", int'(busy), 0);
    model_score = 0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; new_game = 1'b0;
    for (int r = 0; r < 20; r++) load_board[r] = 30'd0;
    repeat (3) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_wr_en", int'(wr_en), 0);
    check("reset_wr_row", int'(wr_row), 0);
    check("reset_wr_data", int'(wr_data), 0);
    check("reset_rd_row", int'(rd_row), 0);
    check("reset_lines", int'(lines), 0);
    check("reset_score", int'(score), 0);
    rst_n = 1'b1;
    @(negedge clk);

    make_board(20'h00000); run_pass(1'b0, 1'b0);   // nothing full
    make_board(20'h80000); run_pass(1'b0, 1'b0);   // bottom row full
    make_board(20'hF0000); run_pass(1'b0, 1'b0);   // rows 16..19 full
    make_board(20'h80400); run_pass(1'b0, 1'b0);   // rows 10 and 19
    make_board(20'h00001); run_pass(1'b0, 1'b0);   // top row only
    make_board(20'hFFFFF); run_pass(1'b0, 1'b0);   // whole board full

    @(negedge clk); force dut.score_r = 16'hFFFC;
    @(negedge clk); release dut.score_r;
    model_score = 65532;
    check("score_preload", int'(score), 65532);
    make_board(20'hF0000); run_pass(1'b0, 1'b0);   // saturates
    make_board(20'h80000); run_pass(1'b0, 1'b0);   // stays saturated
    make_board(20'h30000); run_pass(1'b1, 1'b0);   // new game in DONE wins

    make_board(20'h0000F); run_pass(1'b0, 1'b1);   // start during SCAN ignored
    repeat (40) @(negedge clk);

    reset_mid_pass();

    for (int n = 0; n < 25; n++) begin
      logic [19:0] m;
      m = 20'($urandom) & 20'($urandom);
      make_board(m);
      run_pass($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
    end

    new_game = 1'b1;
    @(negedge clk); new_game = 1'b0;
    check("new_game_idle", int'(score), 0);
    repeat (5) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/line_clear_engine.md
LINE_CLEAR_ENGINE -- requirements
Module: line_clear_engine

Interface
REQ-001 SHALL have ports: i_clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have ports: i_rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: i_start  in  1  one-cycle request to compact the board after a piece locks.
REQ-004 SHALL have ports: i_new_game  in  1  clear accumulated score.
REQ-005 SHALL have ports: o_rd_row  out  5  board row read address (0 = top, 19 = bottom).
REQ-006 SHALL have ports: i_rd_data  in  30  row contents, combinational in o_rd_row; cell c at bits [3c+2:3c], c = 0..9; code 0 = empty.
REQ-007 SHALL have ports: o_wr_en  out  1  row write strobe; o_wr_row  out  5  write address; o_wr_data  out  30  write data.
REQ-008 SHALL have ports: o_busy  out  1  engine active; o_done  out  1  one-cycle completion pulse.
REQ-009 SHALL have ports: o_lines  out  5  rows cleared by last pass (0..20); o_score  out  16  accumulated score.

Function
REQ-010 SHALL implement FSM states IDLE, SCAN, FILL, DONE.
REQ-011 IDLE: i_start=1 -> SCAN next cycle; src <= 19, dst <= 19, cnt <= 0; otherwise hold.
REQ-012 i_start SHALL be ignored in every state except IDLE.
REQ-013 SCAN: o_rd_row = src; row full = all 10 cells nonzero.
REQ-014 SCAN, full row: o_wr_en = 0, cnt += 1, src -= 1, dst unchanged.
REQ-015 SCAN, non-full row: o_wr_en = 1, o_wr_row = dst, o_wr_data = i_rd_data (written even when dst == src), src -= 1, dst -= 1.
REQ-016 SCAN SHALL last exactly 20 cycles (src 19..0); after src = 0 -> FILL if cnt > 0, else DONE.
REQ-017 FILL: o_wr_en = 1, o_wr_row = dst, o_wr_data = 0, dst -= 1; after the write to row 0 -> DONE; FILL lasts exactly cnt cycles.
REQ-018 DONE: o_done = 1 for one cycle, o_lines <= cnt, score update; -> IDLE next cycle.
REQ-019 Score increment by cnt: 0->0, 1->1, 2->3, 3->5, >=4->8; add SHALL saturate at 16'hFFFF.
REQ-020 i_new_game=1 SHALL set o_score to 0 on the next edge in any state; takes priority over a same-cycle DONE increment (increment lost); SHALL NOT affect FSM or o_lines.
REQ-021 o_busy = 1 in SCAN, FILL and DONE; 0 in IDLE.
REQ-022 o_wr_en = 0 in IDLE and DONE; o_rd_row = 0, o_wr_row = 0, o_wr_data = 0 whenever not driven by REQ-013..017.
REQ-023 Pass latency from i_start edge to o_done = 20 + cnt + 1 cycles.
REQ-024 src/dst decrement SHALL never wrap below 0; no write issued outside rows 0..19.
REQ-025 o_lines SHALL hold its value until the next DONE.

Reset
REQ-026 i_rst_n=0 SHALL immediately force state IDLE, o_busy=0, o_done=0, o_wr_en=0, o_rd_row=0, o_wr_row=0, o_wr_data=0, o_lines=0, o_score=0, src=dst=19, cnt=0.
REQ-027 Reset mid-pass SHALL abort with no further writes; board contents left as partially written, no score update.

Verification
REQ-028 No full rows, i_start -> 20 writes, each row rewritten to itself, no FILL, o_done at cycle 21, o_lines=0, score unchanged.
REQ-029 Row 19 full, rows 0..18 alternate patterns -> rows 18..0 copied to 19..1, row 0 zeroed, o_lines=1, score +1, o_done at cycle 22.
REQ-030 Rows 16..19 full -> 4 FILL writes zero rows 0..3, o_lines=4, score +8; non-adjacent full rows 10 and 19 -> o_lines=2, score +3, remaining rows contiguous.
REQ-031 Preload score 16'hFFFC, clear 4 rows -> o_score=16'hFFFF; i_new_game asserted in the DONE cycle -> o_score=0.
REQ-032 i_start pulsed during SCAN -> ignored, single o_done; i_rst_n low at SCAN cycle 7 -> o_busy=0, o_wr_en=0 same cycle, o_score=0.
